// File: rtl/ddram_if.sv
// DDRAM Avalon-style port between the PGM core (master) and a memory responder (slave).
interface ddram_if;
  logic        ddram_rd;
  logic        ddram_we;
  logic [28:0] ddram_addr;
  logic [3:0]  ddram_burstcnt;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;

  modport master (
    output ddram_rd, ddram_we, ddram_addr, ddram_burstcnt, ddram_din, ddram_be,
    input  ddram_busy, ddram_dout, ddram_dout_ready
  );

  modport slave (
    input  ddram_rd, ddram_we, ddram_addr, ddram_burstcnt, ddram_din, ddram_be,
    output ddram_busy, ddram_dout, ddram_dout_ready
  );
endinterface

// File: rtl/ddram_responder.sv
// On-chip DDRAM responder backed by a 2^ADDR_BITS x 64-bit RAM with burst read/write.
// Define DDRAM_RESP_STALL_EN to inject pseudo-random busy stalls in IDLE and WR_BURST.
module ddram_responder #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned RD_LATENCY = 4   // legal range 2..15
) (
  input  logic    fixed_50m_clk,
  input  logic    reset,
  ddram_if.slave  ddram
);
  localparam int unsigned          DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [3:0]           LAT_LOAD = 4'(RD_LATENCY - 2);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_t;

  state_t               r_state;
  logic [63:0]          r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_addr;
  logic [3:0]           r_beats;
  logic [3:0]           r_lat;
  logic                 r_busy;
  logic                 r_dout_ready;
  logic [63:0]          r_dout;

  logic                 w_accept;
  logic                 w_wr_en;
  logic                 w_stall_next;
  logic [ADDR_BITS-1:0] w_req_addr;
  logic [ADDR_BITS-1:0] w_wr_addr;
  logic [3:0]           w_len;
  logic                 w_unused;

  // Upper address bits alias onto the decoded window.
  assign w_req_addr = ddram.ddram_addr[ADDR_BITS-1:0];
  assign w_unused   = &{1'b0, ddram.ddram_addr[28:ADDR_BITS]};
  assign w_len      = (ddram.ddram_burstcnt == 4'd0) ? 4'd1 : ddram.ddram_burstcnt;
  assign w_accept   = (ddram.ddram_rd | ddram.ddram_we) & ~r_busy;
  assign w_wr_en    = w_accept & ddram.ddram_we & ((r_state == IDLE) | (r_state == WR_BURST));
  assign w_wr_addr  = (r_state == IDLE) ? w_req_addr : r_addr;

`ifdef DDRAM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;

  assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  // Busy is registered, so stall on the LFSR value that will be current next cycle.
  assign w_stall_next = (w_lfsr_next[1:0] == 2'b00);

  always_ff @(posedge fixed_50m_clk or posedge reset) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= w_lfsr_next;
  end
`else
  assign w_stall_next = 1'b0;
`endif

  // NOTE: the RAM has no reset so it maps onto block RAM and survives a reset.
  always_ff @(posedge fixed_50m_clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (ddram.ddram_be[b]) r_mem[w_wr_addr][8*b +: 8] <= ddram.ddram_din[8*b +: 8];
      end
    end
  end

  always_ff @(posedge fixed_50m_clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_dout_ready <= 1'b0;
      r_dout       <= '0;
      r_addr       <= '0;
      r_beats      <= '0;
      r_lat        <= '0;
    end else begin
      r_dout_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_busy <= w_stall_next;
          if (w_accept && ddram.ddram_we) begin
            r_addr  <= w_req_addr + ADDR_ONE;
            r_beats <= w_len - 4'd1;
            r_state <= (w_len > 4'd1) ? WR_BURST : IDLE;
          end else if (w_accept) begin
            r_addr  <= w_req_addr;
            r_beats <= w_len - 4'd1;
            r_lat   <= LAT_LOAD;
            r_busy  <= 1'b1;
            r_state <= RD_WAIT;
          end
        end
        WR_BURST: begin
          r_busy <= w_stall_next;
          if (w_accept && ddram.ddram_we) begin
            r_addr  <= r_addr + ADDR_ONE;
            r_beats <= r_beats - 4'd1;
            if (r_beats == 4'd1) r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          // First beat leaves here; r_beats already counts the beats after it.
          if (r_lat == 4'd0) begin
            r_dout       <= r_mem[r_addr];
            r_dout_ready <= 1'b1;
            r_addr       <= r_addr + ADDR_ONE;
            r_state      <= RD_DATA;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        RD_DATA: begin
          if (r_beats == 4'd0) begin
            r_busy  <= w_stall_next;
            r_state <= IDLE;
          end else begin
            r_dout       <= r_mem[r_addr];
            r_dout_ready <= 1'b1;
            r_addr       <= r_addr + ADDR_ONE;
            r_beats      <= r_beats - 4'd1;
          end
        end
      endcase
    end
  end

  assign ddram.ddram_busy       = r_busy;
  assign ddram.ddram_dout       = r_dout;
  assign ddram.ddram_dout_ready = r_dout_ready;
endmodule

// File: tb/tb_ddram_responder.sv
// Self-checking bench for ddram_responder: directed corner cases plus random bursts
// checked against a flat word-array model of the RAM and the read timing rules.
module tb_ddram_responder;
  localparam int unsigned ADDR_BITS  = 12;
  localparam int unsigned RD_LATENCY = 4;
  localparam int          DEPTH      = 1 << ADDR_BITS;

  logic fixed_50m_clk = 1'b0;
  logic reset         = 1'b1;

  ddram_if bus ();

  ddram_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .fixed_50m_clk (fixed_50m_clk),
    .reset         (reset),
    .ddram         (bus)
  );

  always #5 fixed_50m_clk = ~fixed_50m_clk;

  logic [63:0] model [DEPTH];
  logic [63:0] wd [16];
  logic [7:0]  wb [16];
  int          wr_addrs [1000];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          seen_idle_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic drive_idle();
    bus.ddram_rd       = 1'b0;
    bus.ddram_we       = 1'b0;
    bus.ddram_addr     = '0;
    bus.ddram_burstcnt = '0;
    bus.ddram_din      = '0;
    bus.ddram_be       = '0;
  endtask

  task automatic model_write(input int a, input logic [63:0] d, input logic [7:0] be);
    for (int b = 0; b < 8; b++) begin
      if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Called just after a negedge with the request driven; returns at the negedge
  // following the accepting posedge.
  task automatic wait_accept(input string tag, input bit idle_phase, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.ddram_busy) begin
        ok = 1'b1;
        break;
      end
      if (idle_phase) seen_idle_stall = 1'b1;
      @(negedge fixed_50m_clk);
    end
    if (ok) begin
      @(posedge fixed_50m_clk);
      @(negedge fixed_50m_clk);
    end else begin
      check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    end
  endtask

  // Beats come from wd/wb; one we=0 gap cycle is inserted after beat index gap_after.
  task automatic write_burst(input logic [28:0] addr, input logic [3:0] bc, input int gap_after);
    int n;
    int a;
    bit ok;
    n = (bc == 4'd0) ? 1 : int'(bc);
    a = int'(addr[ADDR_BITS-1:0]);
    for (int i = 0; i < n; i++) begin
      bus.ddram_we       = 1'b1;
      bus.ddram_din      = wd[i];
      bus.ddram_be       = wb[i];
      bus.ddram_rd       = (i == 0) ? 1'b0 : 1'($urandom);
      bus.ddram_addr     = (i == 0) ? addr : 29'($urandom);
      bus.ddram_burstcnt = (i == 0) ? bc : 4'($urandom);
      wait_accept("wr", i == 0, ok);
      drive_idle();
      if (!ok) return;
      model_write(a, wd[i], wb[i]);
      a = (a + 1) % DEPTH;
      if (i == gap_after) @(negedge fixed_50m_clk);
    end
  endtask

  task automatic read_burst(input logic [28:0] addr, input logic [3:0] bc, input string tag);
    int   n;
    int   a;
    int   beat;
    bit   ok;
    bit   exp_rdy;
    n = (bc == 4'd0) ? 1 : int'(bc);
    a = int'(addr[ADDR_BITS-1:0]);
    bus.ddram_rd       = 1'b1;
    bus.ddram_we       = 1'b0;
    bus.ddram_addr     = addr;
    bus.ddram_burstcnt = bc;
    wait_accept({tag, "_rd"}, 1'b1, ok);
    drive_idle();
    if (!ok) return;
    beat = 0;
    // Observation k is the value visible in the k-th cycle after the accepting edge.
    for (int k = 1; k <= int'(RD_LATENCY) + n; k++) begin
      if (k > 1) @(negedge fixed_50m_clk);
      exp_rdy = (k >= int'(RD_LATENCY)) && (k < int'(RD_LATENCY) + n);
      check({tag, "_ready"}, 64'(bus.ddram_dout_ready), 64'(exp_rdy));
      if (exp_rdy) begin
        if (bus.ddram_dout_ready) check({tag, "_data"}, bus.ddram_dout, model[(a + beat) % DEPTH]);
        beat++;
      end
      if (k < int'(RD_LATENCY) + n) check({tag, "_busy_hi"}, 64'(bus.ddram_busy), 64'd1);
`ifndef DDRAM_RESP_STALL_EN
      if (k == int'(RD_LATENCY) + n) check({tag, "_busy_lo"}, 64'(bus.ddram_busy), 64'd0);
`endif
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion, expected finish before 900us");
    $fatal(1);
  end

  initial begin
    int          pulses;
    int          a;
    bit          ok;
    logic [3:0]  bc;
    logic [28:0] ra;

    drive_idle();
    repeat (3) @(negedge fixed_50m_clk);
    check("rst_busy", 64'(bus.ddram_busy), 64'd0);
    check("rst_ready", 64'(bus.ddram_dout_ready), 64'd0);
    check("rst_dout", bus.ddram_dout, 64'd0);
    reset = 1'b0;
    @(negedge fixed_50m_clk);

    // Single write then single read with exact latency.
    wd[0] = 64'h0123456789ABCDEF;
    wb[0] = 8'hFF;
    write_burst(29'h10, 4'd1, -1);
    read_burst(29'h10, 4'd1, "single");

    // Fill the whole RAM with known data, using aliased upper address bits.
    for (int i = 0; i < DEPTH; i += 15) begin
      for (int j = 0; j < 15; j++) begin
        wd[j] = {$urandom, $urandom};
        wb[j] = 8'hFF;
      end
      write_burst({17'($urandom), 12'(i)}, 4'd15, -1);
    end

    // Byte-masked write over zero.
    wd[0] = 64'd0;
    wb[0] = 8'hFF;
    write_burst(29'h20, 4'd1, -1);
    wd[0] = 64'hFFFFFFFF_FFFFFFFF;
    wb[0] = 8'h0F;
    write_burst(29'h20, 4'd1, -1);
    read_burst(29'h20, 4'd1, "partial");

    // Wrapping 4-beat write with a gap between beats 2 and 3, then wrapping read.
    for (int j = 0; j < 4; j++) begin
      wd[j] = 64'(j + 1);
      wb[j] = 8'hFF;
    end
    write_burst(29'hFFE, 4'd4, 1);
    read_burst(29'hFFE, 4'd4, "wrap");

    read_burst(29'($urandom), 4'd0, "bc0");

    // rd and we together in IDLE: the write wins, no read data ever appears.
    bus.ddram_rd       = 1'b1;
    bus.ddram_we       = 1'b1;
    bus.ddram_addr     = 29'h30;
    bus.ddram_burstcnt = 4'd1;
    bus.ddram_din      = {$urandom, $urandom};
    bus.ddram_be       = 8'hFF;
    wd[0]              = bus.ddram_din;
    wait_accept("rdwe", 1'b1, ok);
    drive_idle();
    if (ok) model_write(32'h30, wd[0], 8'hFF);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.ddram_dout_ready) pulses++;
      @(negedge fixed_50m_clk);
    end
    check("rdwe_no_ready", 64'(pulses), 64'd0);
    read_burst(29'h30, 4'd1, "rdwe_rb");

    // Async reset during beat 2 of a 4-beat read.
    bus.ddram_rd       = 1'b1;
    bus.ddram_addr     = 29'h100;
    bus.ddram_burstcnt = 4'd4;
    wait_accept("rstmid", 1'b1, ok);
    drive_idle();
    if (ok) begin
      repeat (RD_LATENCY) @(negedge fixed_50m_clk);
      check("rstmid_beat2_ready", 64'(bus.ddram_dout_ready), 64'd1);
      check("rstmid_beat2_data", bus.ddram_dout, model[32'h101]);
      #1 reset = 1'b1;
      #1;
      check("rstmid_ready_low", 64'(bus.ddram_dout_ready), 64'd0);
      check("rstmid_busy_low", 64'(bus.ddram_busy), 64'd0);
      check("rstmid_dout_zero", bus.ddram_dout, 64'd0);
      @(negedge fixed_50m_clk);
      @(negedge fixed_50m_clk);
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge fixed_50m_clk);
        if (bus.ddram_dout_ready) pulses++;
      end
      check("rstmid_no_more_beats", 64'(pulses), 64'd0);
    end
    read_burst(29'h100, 4'd4, "rstmid_rb");

    // Random mix of bursts.
    for (int it = 0; it < 150; it++) begin
      bc = 4'($urandom);
      ra = 29'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        for (int j = 0; j < 16; j++) begin
          wd[j] = {$urandom, $urandom};
          wb[j] = 8'($urandom);
        end
        write_burst(ra, bc, int'($urandom_range(15, 0)) - 1);
      end else begin
        read_burst(ra, bc, "rnd");
      end
    end

    // Bulk single-word writes followed by readback.
    for (int i = 0; i < 1000; i++) begin
      a           = int'($urandom_range(DEPTH - 1, 0));
      wr_addrs[i] = a;
      wd[0]       = {$urandom, $urandom};
      wb[0]       = 8'($urandom);
      write_burst({17'($urandom), 12'(a)}, 4'd1, -1);
    end
    for (int i = 0; i < 1000; i++) begin
      read_burst(29'(wr_addrs[i]), 4'd1, "bulk");
    end

`ifdef DDRAM_RESP_STALL_EN
    check("idle_stall_seen", 64'(seen_idle_stall), 64'd1);
`else
    check("idle_never_busy", 64'(seen_idle_stall), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ddram_responder.md
Name: ddram_responder

Overview:
- On-chip responder for the DDRAM Avalon-style port that the PGM core drives as initiator: rd/we, 29-bit word address, 64-bit data, byte enables, burst count.
- Answers with busy, dout and dout_ready from a local 64-bit block RAM.
- Stands in for the HPS DDR path in simulation, and in on-chip builds for small asset windows.
- Sits between pgm_core's ddram_* ports and emu's DDRAM_* pins; selected by build.

Parameters:
- ADDR_BITS, 12, word-address bits decoded; memory depth = 2^ADDR_BITS x 64-bit; upper address bits ignored (aliasing).
- RD_LATENCY, 4, cycles from read acceptance to first dout_ready; legal range 2..15.

Ports:
- fixed_50m_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- ddram_rd  in  1  read request.
- ddram_we  in  1  write request / write burst beat.
- ddram_addr  in  29  64-bit word address, sampled only on the first beat.
- ddram_burstcnt  in  4  beats per burst; 0 is treated as 1.
- ddram_din  in  64  write data.
- ddram_be  in  8  byte enables; bit n covers din[8n+7:8n].
- ddram_busy  out  1  waitrequest; a request or beat is accepted only when busy=0.
- ddram_dout  out  64  read data.
- ddram_dout_ready  out  1  one-cycle strobe per read beat.

Behaviour:
- Reset (async assert): state=IDLE, busy=0, dout_ready=0, dout=0, beat counter=0, latency counter=0.
- Reset does not clear RAM contents. Reset mid-burst abandons the burst; any undelivered read beats are never issued.
- Accept condition: (rd|we) && !busy at a rising edge. All outputs are registered.
- FSM states: IDLE, WR_BURST, RD_WAIT, RD_DATA.
- IDLE, write accepted:
  - Byte-masked write to mem[addr[ADDR_BITS-1:0]] at that edge.
  - beats_left = max(burstcnt,1) - 1.
  - Next state is WR_BURST if beats_left > 0, else IDLE.
- IDLE, read accepted:
  - Latch base address and burst length.
  - Next state RD_WAIT; busy=1 from the next cycle.
- IDLE, rd and we both high: write wins and the read is dropped (initiator protocol violation). No error flag.
- WR_BURST:
  - busy=0 (absent stall injection).
  - Each cycle with we=1 writes the next sequential word, masked by that beat's be. ddram_addr and burstcnt are ignored.
  - Cycles with we=0 are idle gaps; the burst waits indefinitely.
  - rd is ignored.
  - After the last beat, return to IDLE.
- RD_WAIT:
  - busy=1. The latency counter counts so that the first dout_ready is asserted exactly RD_LATENCY cycles after the acceptance edge.
  - Then RD_DATA.
- RD_DATA:
  - One beat per consecutive cycle, with sequential addresses wrapping modulo 2^ADDR_BITS.
  - dout is valid only when dout_ready=1; otherwise dout holds its last value.
  - After the last beat, next state is IDLE and busy drops on the following cycle.
- Read-after-write: a read accepted the cycle after a write edge returns the new data.
- Address wrap: a burst starting at 2^ADDR_BITS-1 continues at word 0.
- One outstanding read at a time; no read pipelining.

Optional Feature:
- Macro: DDRAM_RESP_STALL_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every cycle.
  - When LFSR[1:0]==2'b00, busy is forced high in IDLE and WR_BURST for that cycle. Requests and beats presented that cycle are not accepted.
  - RD_DATA timing is unaffected.
- When undefined: no LFSR; busy follows the FSM only.

Test Plan:
- Reset, then single write: addr=0x10, din=64'h0123456789ABCDEF, be=8'hFF, burstcnt=1. Then read addr=0x10, burstcnt=1 -> dout_ready pulses once exactly 4 cycles after acceptance with dout=64'h0123456789ABCDEF; busy high for cycles 1..4 after acceptance, low on cycle 5.
- Partial write: be=8'h0F, din=64'hFFFFFFFF_FFFFFFFF over stored 0 -> read returns 64'h00000000_FFFFFFFF.
- Write burst: burstcnt=4 at addr=0xFFE with ADDR_BITS=12, data 1,2,3,4, with a we=0 gap between beats 2 and 3 -> words 0xFFE=1, 0xFFF=2, 0x000=3, 0x001=4. A 4-beat read from 0xFFE returns 1,2,3,4 on consecutive cycles.
- burstcnt=0 read -> exactly one dout_ready. Simultaneous rd=1 and we=1 in IDLE -> write performed, no dout_ready ever.
- Async reset asserted during RD_DATA beat 2 of 4 -> dout_ready=0 and busy=0 immediately, no further beats; the previously written data still reads back after reset.
- With DDRAM_RESP_STALL_EN: 1000 random single-word writes followed by readback -> every word matches, and busy is observed high at least once while in IDLE.
